// File: rtl/regbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbus_pkg
// Description : Shared op encodings, FSM state type and bus-idle constants for
//               the register-bus initiator. Honours REGBUS_INITIATOR_RMW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package regbus_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_RMW   = 2'b10;

   localparam int REGBUS_RD_LATENCY = 1;

   localparam logic        IDLE_R_WN  = 1'b1;
   localparam logic [3:0]  IDLE_WBEN  = 4'h0;
   localparam logic [31:0] IDLE_WDATA = 32'h0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_CAPT  = 3'd2,
      S_RSP   = 3'd3
`ifdef REGBUS_INITIATOR_RMW_EN
      ,
      S_MWR   = 3'd4
`endif
   } state_e;

endpackage
`default_nettype wire

// File: rtl/regbus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : regbus_initiator_if
// Description : Command/response handshake and register-bus signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface regbus_initiator_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [2:0]  req_addr;
   logic [3:0]  req_wben;
   logic [31:0] req_wdata;
   logic [31:0] req_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [2:0]  addr;
   logic [3:0]  wben;
   logic        r_wn;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      input  req_valid, req_op, req_addr, req_wben, req_wdata, req_mask,
      input  rsp_ready, rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output addr, wben, r_wn, wdata
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wben, req_wdata, req_mask,
      output rsp_ready, rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  addr, wben, r_wn, wdata
   );

endinterface
`default_nettype wire

// File: rtl/regbus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : regbus_initiator
// Description : Sequences single read/write (and RMW when REGBUS_INITIATOR_RMW_EN
//               is defined) transactions onto the peripheral register bus.
// Revision    : 1.0 - initial release
// ============================================================================
module regbus_initiator
   import regbus_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   regbus_initiator_if.master bus
);

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [2:0]  addr_q, addr_d;
   logic [3:0]  wben_q, wben_d;
   logic        r_wn_q, r_wn_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        w_legal_op;

`ifdef REGBUS_INITIATOR_RMW_EN
   logic [31:0] wdata_lat_q, wdata_lat_d;
   logic [31:0] mask_q, mask_d;

   assign w_legal_op = (bus.req_op != 2'b11);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdata_lat_q <= '0;
         mask_q      <= '0;
      end else begin
         wdata_lat_q <= wdata_lat_d;
         mask_q      <= mask_d;
      end
   end
`else
   logic w_unused_mask;

   assign w_legal_op    = (bus.req_op == OP_READ) || (bus.req_op == OP_WRITE);
   assign w_unused_mask = ^bus.req_mask;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_READ;
         addr_q      <= '0;
         wben_q      <= IDLE_WBEN;
         r_wn_q      <= IDLE_R_WN;
         wdata_q     <= IDLE_WDATA;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wben_q      <= wben_d;
         r_wn_q      <= r_wn_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Bus outputs are computed for the state being entered, so they are registered.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wben_d      = wben_q;
      r_wn_d      = r_wn_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
`ifdef REGBUS_INITIATOR_RMW_EN
      wdata_lat_d = wdata_lat_q;
      mask_d      = mask_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d   = bus.req_op;
               addr_d = bus.req_addr;
`ifdef REGBUS_INITIATOR_RMW_EN
               wdata_lat_d = bus.req_wdata;
               mask_d      = bus.req_mask;
`endif
               if (w_legal_op) begin
                  state_d = S_ISSUE;
                  if (bus.req_op == OP_WRITE) begin
                     r_wn_d  = 1'b0;
                     wben_d  = bus.req_wben;
                     wdata_d = bus.req_wdata;
                  end else begin
                     r_wn_d  = IDLE_R_WN;
                     wben_d  = IDLE_WBEN;
                     wdata_d = IDLE_WDATA;
                  end
               end else begin
                  state_d     = S_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            r_wn_d  = IDLE_R_WN;
            wben_d  = IDLE_WBEN;
            wdata_d = IDLE_WDATA;
            if (op_q == OP_WRITE) begin
               state_d     = S_RSP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b0;
            end else begin
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            rsp_data_d = bus.rdata;
`ifdef REGBUS_INITIATOR_RMW_EN
            if (op_q == OP_RMW) begin
               state_d = S_MWR;
               r_wn_d  = 1'b0;
               wben_d  = 4'hF;
               wdata_d = (bus.rdata & ~mask_q) | (wdata_lat_q & mask_q);
            end else begin
               state_d     = S_RSP;
               rsp_valid_d = 1'b1;
            end
`else
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
`endif
         end
`ifdef REGBUS_INITIATOR_RMW_EN
         S_MWR: begin
            r_wn_d      = IDLE_R_WN;
            wben_d      = IDLE_WBEN;
            wdata_d     = IDLE_WDATA;
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
         end
`endif
         S_RSP: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.addr      = addr_q;
   assign bus.wben      = wben_q;
   assign bus.r_wn      = r_wn_q;
   assign bus.wdata     = wdata_q;

endmodule
`default_nettype wire

// File: doc/regbus_initiator.md
# regbus_initiator

Register-bus initiator that drives the peripheral register bus (`addr`, `wben`, `r_wn`, `wdata` out; `rdata` in) from a valid/ready command port and returns a valid/ready response. It sits between the core's load/store path, or a debug bridge, and the register-file responder. It sequences single read, write and (optionally) read-modify-write transactions. At most one transaction is in flight at a time.

## Interface
Parameters:
- None. Bus geometry is fixed: word address [4:2] and 32-bit data.

Ports:
- `clk` in 1: master clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when `req_valid && req_ready`.
- `req_op` in 2: 00 read, 01 write, 10 RMW, 11 reserved.
- `req_addr` in 3 [4:2]: register word address.
- `req_wben` in 4: byte enables for write.
- `req_wdata` in 32: write data, or RMW insert data.
- `req_mask` in 32: RMW bit mask; 1 = take bit from `req_wdata`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out 32: read data (read) or pre-modify value (RMW); 0 for write.
- `rsp_err` out 1: reserved or disabled op.
- `addr` out 3 [4:2]: bus address.
- `wben` out 4: bus byte enables.
- `r_wn` out 1: 1 = read, 0 = write.
- `wdata` out 32: bus write data.
- `rdata` in 32: responder read data, registered by the responder one cycle after a read.

## Operation
- States:
  - IDLE: `req_ready`=1. On accept, latch op, addr, wben, wdata and mask.
    - Legal op → ISSUE.
    - Reserved op → RSP with `rsp_err`=1. No bus cycle is issued.
  - ISSUE: drives exactly one bus cycle.
    - Write: `r_wn`=0, `wben`=latched wben, `wdata`=latched wdata. Next state RSP.
    - Read/RMW: `r_wn`=1, `wben`=0. Next state CAPT.
  - CAPT: bus is idle with `addr` held. Sample `rdata` into `rsp_data`.
    - Read → RSP.
    - RMW → MWR.
  - MWR (RMW only): `r_wn`=0, `wben`=4'hF, `wdata`=(captured & ~mask) | (latched wdata & mask). Next state RSP.
  - RSP: `rsp_valid`=1 and all response outputs held stable until `rsp_ready`. Then → IDLE.
- Bus idle value: `r_wn`=1, `wben`=0, `wdata`=0, `addr`=last latched address (0 after reset). An idle read is side-effect-free.
- `req_ready`=0 in every state except IDLE. A request presented while busy is simply not accepted.
- Write with `wben`=0 still issues its bus cycle and responds normally.
- `rsp_err`=0 for every legal op. `rsp_data`=0 for writes and errors.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `addr`=0, `wben`=0, `r_wn`=1, `wdata`=0. State is IDLE.
- All outputs are registered, except `req_ready`, which is decoded from the state register.
- Take accept edge = N. Then:
  - Bus cycle is driven in cycle N+1.
  - Write: `rsp_valid` at N+2.
  - Read: `rdata` is sampled at the end of N+2; `rsp_valid` at N+3.
  - RMW: merge write in N+3; `rsp_valid` at N+4.
  - Reserved op: `rsp_valid` at N+1.
- Back-to-back throughput: the earliest next accept is the cycle after the RSP handshake. There is no accept in the same cycle as the handshake.
- Reset asserted mid-transaction: the FSM aborts immediately and all outputs return to reset values. A half-finished RMW never issues its write.

## Configuration
- `REGBUS_INITIATOR_RMW_EN` defined: op 10 performs ISSUE → CAPT → MWR → RSP as above.
- Not defined:
  - MWR state and merge logic are absent.
  - op 10 is treated as reserved: `rsp_err`=1, no bus cycle.
  - `req_mask` remains a port but is unused.

## Structure
- Shared package `regbus_pkg` holds:
  - op encodings (`OP_READ`, `OP_WRITE`, `OP_RMW`);
  - FSM state enum;
  - bus-idle constants;
  - the `REGBUS_RD_LATENCY`=1 constant.
- No sub-module. The merge is a single expression inside the FSM module.

## Test plan
- Read addr 0 against the register-file responder → `rsp_data`=0x48524A44, `rsp_err`=0, `rsp_valid` at N+3.
- Write addr 2, `wben`=4'b0011, `wdata`=0x0000A5A5, then read addr 2 → write response at N+2, read returns 0x0000A5A5.
- RMW on addr 5 (scratch preloaded 0xFFFF0000), mask 0x000000FF, wdata 0x12345678 → `rsp_data`=0xFFFF0000, subsequent read 0xFFFF0078. Without the macro: `rsp_err`=1 and scratch unchanged.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid`/`rsp_data` stable, `req_ready`=0, no extra bus cycles; accept resumes the cycle after the handshake.
- `req_op`=11 → `rsp_err`=1 at N+1, `r_wn` stays 1 and `wben` stays 0 throughout.
- Assert `reset` low during CAPT of an RMW → outputs at reset values asynchronously, no write cycle is observed, and the next read returns the unmodified value.
